// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and widths for the fetch controller
package fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        ISSUE = 2'b10,
        HALT  = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - enable flop cell with synchronous active-high clear
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over load; otherwise hold unless enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_ctrl_instr_reg.sv
// rtl/fetch_ctrl_instr_reg.sv - holding register for the fetched instruction word
module instr_reg
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wen,
    input  logic [INSTR_W-1:0] d,
    output logic [INSTR_W-1:0] q
);

    dff #(.W(INSTR_W)) u_word (
        .clk (clk),
        .rst (rst),
        .en  (wen),
        .d   (d),
        .q   (q)
    );

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencing, imem handshake and instruction issue (option: FETCH_PERF_CNT_EN)
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_INC = 16'd2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_cur,
    output logic [PC_W-1:0]    pc_next,
    output logic               pc_wen,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_target,
    input  logic               halt_dec,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt,
`endif
    output logic               halted
);

    fetch_state_t state;
    logic         consume;
    logic         capture;

    // An instruction leaves ISSUE only when decode is not stalling
    assign consume = (state == ISSUE) && !stall;
    assign capture = (state == FETCH) && imem_ready;

    // State sequencing; reset from any state discards an in-flight response
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= FETCH;
                FETCH:   state <= imem_ready ? ISSUE : FETCH;
                ISSUE:   begin
                    if (!stall) begin
                        state <= halt_dec ? HALT : FETCH;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    instr_reg u_instr_reg (
        .clk (clk),
        .rst (rst),
        .wen (capture),
        .d   (imem_data),
        .q   (instr)
    );

    assign imem_req    = (state == FETCH);
    assign imem_addr   = (state == FETCH) ? pc_cur : '0;
    assign instr_valid = (state == ISSUE);
    assign halted      = (state == HALT);
    assign pc_wen      = consume && !halt_dec;

    // Branch targets are forced to instruction alignment; sequential fetch wraps mod 2^16
    always_comb begin
        pc_next = pc_cur;
        if (pc_wen) begin
            if (redirect) begin
                pc_next = redirect_target & ~16'h0001;
            end else begin
                pc_next = pc_cur + PC_INC;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counts of consumed instructions and stalled issue cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (consume && (fetch_cnt != 16'hFFFF)) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if ((state == ISSUE) && stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_cur;
    logic [15:0] pc_next;
    logic        pc_wen;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        halt_dec;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    logic        pc_load;
    logic [15:0] pc_load_val;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_instr_q[$];
    logic [15:0] exp_pc;
    logic [15:0] held_instr;
    int          exp_fetch_cnt;
    int          exp_stall_cnt;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .pc_cur          (pc_cur),
        .pc_next         (pc_next),
        .pc_wen          (pc_wen),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_data       (imem_data),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt_dec        (halt_dec),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt       (fetch_cnt),
        .stall_cnt       (stall_cnt),
`endif
        .halted          (halted)
    );

    // PC register model sitting downstream of pc_next/pc_wen
    always @(posedge clk) begin
        if (rst) pc_cur <= 16'h0000;
        else if (pc_load) pc_cur <= pc_load_val;
        else if (pc_wen) pc_cur <= pc_next;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one FETCH phase with a number of wait cycles, then checks the issued word
    task automatic fetch_one(input logic [15:0] data, input int waits);
        logic [15:0] e;
        for (int w = 0; w <= waits; w++) begin
            imem_ready = (w == waits);
            imem_data  = data;
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || pc_wen !== 1'b0) begin
                errors++;
                $display("FAIL fetch_req w=%0d: req=%b addr=%h wen=%b, required req=1 addr=%h wen=0",
                         w, imem_req, imem_addr, pc_wen, exp_pc);
            end
            if (w == waits) exp_instr_q.push_back(data);
            step();
        end
        imem_ready = 1'b0;
        imem_data  = 16'hDEAD;
        e = exp_instr_q.pop_front();
        held_instr = e;
        checks++;
        if (instr_valid !== 1'b1 || instr !== e || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL issue_word: valid=%b instr=%h req=%b, required valid=1 instr=%h req=0",
                     instr_valid, instr, imem_req, e);
        end
    endtask

    // Holds ISSUE for some stall cycles, then consumes with the given redirect/halt
    task automatic consume(input int stalls, input logic rd, input logic [15:0] tgt, input logic hl);
        logic [15:0] e_next;
        for (int s = 0; s < stalls; s++) begin
            stall           = 1'b1;
            redirect        = s[0] ? 1'b0 : 1'b1;
            halt_dec        = (s == 1);
            redirect_target = 16'h5555;
            #1;
            checks++;
            if (pc_wen !== 1'b0 || instr !== held_instr || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold s=%0d: wen=%b instr=%h valid=%b, required wen=0 instr=%h valid=1",
                         s, pc_wen, instr, instr_valid, held_instr);
            end
            exp_stall_cnt++;
            step();
        end
        stall           = 1'b0;
        redirect        = rd;
        redirect_target = tgt;
        halt_dec        = hl;
        #1;
        if (hl) e_next = exp_pc;
        else if (rd) e_next = {tgt[15:1], 1'b0};
        else e_next = exp_pc + 16'd2;
        checks++;
        if (pc_wen !== !hl || (!hl && pc_next !== e_next)) begin
            errors++;
            $display("FAIL consume: wen=%b next=%h, required wen=%b next=%h",
                     pc_wen, pc_next, !hl, e_next);
        end
        exp_fetch_cnt++;
        step();
        exp_pc          = e_next;
        redirect        = 1'b0;
        halt_dec        = 1'b0;
        redirect_target = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc_wen !== 1'b0 ||
            halted !== 1'b0 || instr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b req=%b wen=%b halted=%b instr=%h, required all 0",
                     instr_valid, imem_req, pc_wen, halted, instr);
        end
        rst = 1'b0;
        exp_pc = 16'h0000;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle: req=%b, required 0", imem_req);
        end
        step();
    endtask

    task automatic test_zero_wait();
        fetch_one(16'h1234, 0);
        consume(0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_mem_wait();
        fetch_one(16'hBEEF, 3);
        checks++;
        if (pc_cur !== 16'h0002) begin
            errors++;
            $display("FAIL pc_before_consume: pc=%h, required 0002", pc_cur);
        end
        consume(0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_stall();
        fetch_one(16'hA5A5, 0);
        consume(4, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_redirect();
        fetch_one(16'h0F0F, 0);
        consume(0, 1'b1, 16'h00A5, 1'b0);
        fetch_one(16'h1111, 0);
        consume(0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_wrap();
        pc_load     = 1'b1;
        pc_load_val = 16'hFFFE;
        step();
        pc_load = 1'b0;
        exp_pc  = 16'hFFFE;
        fetch_one(16'h2222, 0);
        consume(0, 1'b0, 16'h0000, 1'b0);
        fetch_one(16'h3333, 0);
        consume(0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_halt_reset();
        fetch_one(16'hF000, 0);
        consume(0, 1'b1, 16'h1234, 1'b1);
        for (int c = 0; c < 4; c++) begin
            imem_ready = 1'b1;
            stall      = c[0];
            redirect   = 1'b1;
            halt_dec   = c[1];
            #1;
            checks++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || pc_wen !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold c=%0d: halted=%b req=%b wen=%b valid=%b, required 1 0 0 0",
                         c, halted, imem_req, pc_wen, instr_valid);
            end
            step();
        end
        imem_ready = 1'b0;
        stall      = 1'b0;
        redirect   = 1'b0;
        halt_dec   = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if (halted !== 1'b0 || imem_req !== 1'b0 || instr !== 16'h0000) begin
            errors++;
            $display("FAIL halt_exit: halted=%b req=%b instr=%h, required 0 0 0000",
                     halted, imem_req, instr);
        end
        rst = 1'b0;
        step();
        imem_ready = 1'b1;
        imem_data  = 16'h7777;
        rst        = 1'b1;
        step();
        imem_ready = 1'b0;
        checks++;
        if (instr !== 16'h0000 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fetch: instr=%h valid=%b req=%b, required 0000 0 0",
                     instr, instr_valid, imem_req);
        end
        rst = 1'b0;
        exp_pc = 16'h0000;
        step();
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_pc = 16'h0000;
        exp_fetch_cnt = 0;
        exp_stall_cnt = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            fetch_one(16'h4000 + 16'(i), i % 2);
            consume((i < 3) ? 1 : 0, 1'b0, 16'h0000, 1'b0);
        end
        checks++;
        if (fetch_cnt !== 16'(exp_fetch_cnt) || stall_cnt !== 16'(exp_stall_cnt) ||
            exp_fetch_cnt != 5 || exp_stall_cnt != 3) begin
            errors++;
            $display("FAIL perf_counts: fetch=%0d stall=%0d, required 5 3", fetch_cnt, stall_cnt);
        end
        imem_ready = 1'b1;
        rst        = 1'b1;
        step();
        imem_ready = 1'b0;
        checks++;
        if (fetch_cnt !== 16'h0000 || stall_cnt !== 16'h0000 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL perf_reset: fetch=%0d stall=%0d req=%b, required 0 0 0",
                     fetch_cnt, stall_cnt, imem_req);
        end
        rst = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        pc_load         = 1'b0;
        pc_load_val     = 16'h0000;
        imem_ready      = 1'b0;
        imem_data       = 16'h0000;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 16'h0000;
        halt_dec        = 1'b0;
        exp_pc          = 16'h0000;
        held_instr      = 16'h0000;
        exp_fetch_cnt   = 0;
        exp_stall_cnt   = 0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_mem_wait();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
